// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM sharing one memory port for fetch and data access.
// Optional macro BNE_EN adds bne (opcode 000101) as a branch-if-not-equal.
module mc_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             memwrite,
    output logic             iord,
    output logic             irwrite,
    output logic             pcen,
    output logic [1:0]       pcsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       op,
    output logic             regwrite,
    output logic             regdst,
    output logic             mem2reg,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [RET_W-1:0] retired,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_EXEC_I = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_FAULT  = 4'd12
    } state_t;

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [RET_W-1:0] retired_q;
    logic             fault_q;
    logic [1:0]       fault_code_q, fault_code_d;
    logic             retire;
    logic             mem_wait;
    logic             timeout;

    logic       c_mem_req, c_memwrite, c_iord, c_irwrite, c_pcen;
    logic [1:0] c_pcsrc, c_alusrcb;
    logic       c_alusrca;
    logic [2:0] c_op;
    logic       c_regwrite, c_regdst, c_mem2reg;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr_bits;

    assign opcode            = instr[31:26];
    assign funct             = instr[5:0];
    assign unused_instr_bits = ^instr[25:6];

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100100) || (f == 6'b100101) ||
               (f == 6'b100010) || (f == 6'b101010);
    endfunction

    function automatic logic [2:0] funct_op(input logic [5:0] f);
        case (f)
            6'b100100: return 3'b100;
            6'b100101: return 3'b010;
            6'b100010: return 3'b011;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                      && !mem_ready;
    // The limit is hit on the wait cycle that would bring the count up to MEM_TIMEOUT.
    assign timeout  = (MEM_TIMEOUT != 0) && mem_wait && (wait_q == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        retire       = 1'b0;
        c_mem_req    = 1'b0;
        c_memwrite   = 1'b0;
        c_iord       = 1'b0;
        c_irwrite    = 1'b0;
        c_pcen       = 1'b0;
        c_pcsrc      = 2'b00;
        c_alusrca    = 1'b0;
        c_alusrcb    = 2'b00;
        c_op         = 3'b000;
        c_regwrite   = 1'b0;
        c_regdst     = 1'b0;
        c_mem2reg    = 1'b0;

        case (state_q)
            S_FETCH: begin
                c_mem_req = 1'b1;
                c_alusrcb = 2'b01;
                if (mem_ready) begin
                    c_irwrite = 1'b1;
                    c_pcen    = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                c_alusrcb = 2'b11;
                case (opcode)
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000000: begin
                        if (funct_legal(funct)) begin
                            state_d = S_EXEC_R;
                        end else begin
                            state_d      = S_FAULT;
                            fault_code_d = 2'b01;
                        end
                    end
                    6'b001000: state_d = S_EXEC_I;
                    6'b000100: state_d = S_BRANCH;
`ifdef BNE_EN
                    6'b000101: state_d = S_BRANCH;
`endif
                    6'b000010: state_d = S_JUMP;
                    default: begin
                        state_d      = S_FAULT;
                        fault_code_d = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                c_alusrca = 1'b1;
                c_alusrcb = 2'b10;
                state_d   = opcode[3] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                c_mem_req = 1'b1;
                c_iord    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                c_regwrite = 1'b1;
                c_mem2reg  = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                c_mem_req  = 1'b1;
                c_memwrite = 1'b1;
                c_iord     = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC_R: begin
                c_alusrca = 1'b1;
                c_op      = funct_op(funct);
                state_d   = S_RWB;
            end
            S_RWB: begin
                c_regwrite = 1'b1;
                c_regdst   = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_EXEC_I: begin
                c_alusrca = 1'b1;
                c_alusrcb = 2'b10;
                state_d   = S_IWB;
            end
            S_IWB: begin
                c_regwrite = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                c_alusrca = 1'b1;
                c_op      = 3'b011;
                c_pcsrc   = 2'b01;
`ifdef BNE_EN
                c_pcen    = opcode[0] ? ~zero : zero;
`else
                c_pcen    = zero;
`endif
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_JUMP: begin
                c_pcsrc = 2'b10;
                c_pcen  = 1'b1;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: ;
        endcase

        if (timeout) begin
            state_d      = S_FAULT;
            fault_code_d = 2'b10;
        end

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_wait) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            wait_q       <= '0;
            retired_q    <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            fault_q      <= fault_q | (state_d == S_FAULT);
            fault_code_q <= fault_code_d;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    // Reset suppresses every control strobe so no request escapes mid-instruction.
    assign mem_req    = c_mem_req  & ~rst;
    assign memwrite   = c_memwrite & ~rst;
    assign iord       = c_iord     & ~rst;
    assign irwrite    = c_irwrite  & ~rst;
    assign pcen       = c_pcen     & ~rst;
    assign pcsrc      = c_pcsrc    & {2{~rst}};
    assign alusrca    = c_alusrca  & ~rst;
    assign alusrcb    = c_alusrcb  & {2{~rst}};
    assign op         = c_op       & {3{~rst}};
    assign regwrite   = c_regwrite & ~rst;
    assign regdst     = c_regdst   & ~rst;
    assign mem2reg    = c_mem2reg  & ~rst;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign retired    = retired_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller (MEM_TIMEOUT=4, RET_W=4).
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, memwrite, iord, irwrite, pcen, alusrca;
    logic [1:0]  pcsrc, alusrcb, fault_code;
    logic [2:0]  op;
    logic        regwrite, regdst, mem2reg, fault;
    logic [3:0]  retired;
    logic [3:0]  state;
    logic [15:0] ctl;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [3:0]  exp_ret;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC_R = 4'd6, S_RWB = 4'd7,
                           S_EXEC_I = 4'd8, S_IWB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
                           S_FAULT = 4'd12;

    mc_controller #(.MEM_TIMEOUT(4), .RET_W(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .op(op),
        .regwrite(regwrite), .regdst(regdst), .mem2reg(mem2reg), .fault(fault),
        .fault_code(fault_code), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    // {mem_req,memwrite,iord,irwrite,pcen,pcsrc,alusrca,alusrcb,op,regwrite,regdst,mem2reg}
    assign ctl = {mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb, op,
                  regwrite, regdst, mem2reg};

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_ret = 4'd0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = 32'h0; zero = 1'b0; mem_ready = 1'b1;
        step();
        step();
        n_cmp++; if (ctl !== 16'h0) begin n_fail++; $display("FAIL reset_ctl: got %h want %h", ctl, 16'h0); end
        n_cmp++; if (state !== S_FETCH) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, S_FETCH); end
        n_cmp++; if (retired !== 4'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired); end
        n_cmp++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
        n_cmp++; if (fault_code !== 2'b00) begin n_fail++; $display("FAIL reset_code: got %b want 00", fault_code); end
        rst = 1'b0;
        exp_ret = 4'd0;
        #1;
        n_cmp++; if (ctl !== 16'h9840) begin n_fail++; $display("FAIL reset_fetch_ctl: got %h want %h", ctl, 16'h9840); end
    endtask

    task automatic test_lw();
        logic [3:0]  es[$];
        logic [15:0] ec[$];
        es = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
        ec = '{16'h9840, 16'h00C0, 16'h0180, 16'hA000, 16'h0005};
        instr = 32'h8C080004; mem_ready = 1'b1;
        for (int i = 0; i < es.size(); i++) begin
            #1;
            n_cmp++; if (state !== es[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, es[i]); end
            n_cmp++; if (ctl !== ec[i]) begin n_fail++; $display("FAIL lw_ctl[%0d]: got %h want %h", i, ctl, ec[i]); end
            step();
        end
        exp_ret = exp_ret + 4'd1;
        n_cmp++; if (state !== S_FETCH) begin n_fail++; $display("FAIL lw_end_state: got %0d want %0d", state, S_FETCH); end
        n_cmp++; if (retired !== exp_ret) begin n_fail++; $display("FAIL lw_retired: got %0d want %0d", retired, exp_ret); end
    endtask

    // sw with three wait cycles in FETCH and three in MEMWR: one short of the timeout each time.
    task automatic test_mem_wait();
        logic [3:0]  es[$];
        logic [15:0] ec[$];
        logic        rd[$];
        es = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEMADR,
               S_MEMWR, S_MEMWR, S_MEMWR, S_MEMWR};
        ec = '{16'h8040, 16'h8040, 16'h8040, 16'h9840, 16'h00C0, 16'h0180,
               16'hE000, 16'hE000, 16'hE000, 16'hE000};
        rd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        instr = 32'hAC080004;
        for (int i = 0; i < es.size(); i++) begin
            mem_ready = rd[i];
            #1;
            n_cmp++; if (state !== es[i]) begin n_fail++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, es[i]); end
            n_cmp++; if (ctl !== ec[i]) begin n_fail++; $display("FAIL sw_ctl[%0d]: got %h want %h", i, ctl, ec[i]); end
            step();
        end
        mem_ready = 1'b1;
        exp_ret = exp_ret + 4'd1;
        n_cmp++; if (state !== S_FETCH) begin n_fail++; $display("FAIL sw_end_state: got %0d want %0d", state, S_FETCH); end
        n_cmp++; if (fault !== 1'b0) begin n_fail++; $display("FAIL sw_fault: got %b want 0", fault); end
        n_cmp++; if (retired !== exp_ret) begin n_fail++; $display("FAIL sw_retired: got %0d want %0d", retired, exp_ret); end
    endtask

    task automatic test_rtype();
        logic [31:0] ins[$];
        logic [15:0] exop[$];
        logic [3:0]  es[$];
        logic [15:0] ec[$];
        ins  = '{32'h01095020, 32'h0109502A, 32'h01095022, 32'h01095024, 32'h01095025};
        exop = '{16'h0100, 16'h0138, 16'h0118, 16'h0120, 16'h0110};
        es = '{S_FETCH, S_DECODE, S_EXEC_R, S_RWB};
        mem_ready = 1'b1;
        for (int k = 0; k < ins.size(); k++) begin
            instr = ins[k];
            ec = '{16'h9840, 16'h00C0, exop[k], 16'h0006};
            for (int i = 0; i < es.size(); i++) begin
                #1;
                n_cmp++; if (state !== es[i]) begin n_fail++; $display("FAIL rtype%0d_state[%0d]: got %0d want %0d", k, i, state, es[i]); end
                n_cmp++; if (ctl !== ec[i]) begin n_fail++; $display("FAIL rtype%0d_ctl[%0d]: got %h want %h", k, i, ctl, ec[i]); end
                step();
            end
            exp_ret = exp_ret + 4'd1;
            n_cmp++; if (retired !== exp_ret) begin n_fail++; $display("FAIL rtype%0d_retired: got %0d want %0d", k, retired, exp_ret); end
        end
    endtask

    task automatic test_branch();
        logic [15:0] bctl[$];
        logic        zv[$];
        logic [3:0]  es[$];
        logic [15:0] ec[$];
        bctl = '{16'h0B18, 16'h0318};
        zv   = '{1'b1, 1'b0};
        es = '{S_FETCH, S_DECODE, S_BRANCH};
        instr = 32'h11090003; mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            zero = zv[k];
            ec = '{16'h9840, 16'h00C0, bctl[k]};
            for (int i = 0; i < es.size(); i++) begin
                #1;
                n_cmp++; if (state !== es[i]) begin n_fail++; $display("FAIL beq%0d_state[%0d]: got %0d want %0d", k, i, state, es[i]); end
                n_cmp++; if (ctl !== ec[i]) begin n_fail++; $display("FAIL beq%0d_ctl[%0d]: got %h want %h", k, i, ctl, ec[i]); end
                step();
            end
            exp_ret = exp_ret + 4'd1;
            n_cmp++; if (retired !== exp_ret) begin n_fail++; $display("FAIL beq%0d_retired: got %0d want %0d", k, retired, exp_ret); end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [3:0]  es[$];
        logic [15:0] ec[$];
        es = '{S_FETCH, S_DECODE, S_JUMP};
        ec = '{16'h9840, 16'h00C0, 16'h0C00};
        instr = 32'h08000010; mem_ready = 1'b1;
        for (int i = 0; i < es.size(); i++) begin
            #1;
            n_cmp++; if (state !== es[i]) begin n_fail++; $display("FAIL j_state[%0d]: got %0d want %0d", i, state, es[i]); end
            n_cmp++; if (ctl !== ec[i]) begin n_fail++; $display("FAIL j_ctl[%0d]: got %h want %h", i, ctl, ec[i]); end
            step();
        end
        exp_ret = exp_ret + 4'd1;
        n_cmp++; if (retired !== exp_ret) begin n_fail++; $display("FAIL j_retired: got %0d want %0d", retired, exp_ret); end
    endtask

    // 16 addi on a 4-bit counter must pass through 15 -> 0.
    task automatic test_wrap();
        logic [3:0]  es[$];
        logic [15:0] ec[$];
        es = '{S_FETCH, S_DECODE, S_EXEC_I, S_IWB};
        ec = '{16'h9840, 16'h00C0, 16'h0180, 16'h0004};
        instr = 32'h21080001; mem_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < es.size(); i++) begin
                #1;
                n_cmp++; if (state !== es[i]) begin n_fail++; $display("FAIL addi%0d_state[%0d]: got %0d want %0d", k, i, state, es[i]); end
                n_cmp++; if (ctl !== ec[i]) begin n_fail++; $display("FAIL addi%0d_ctl[%0d]: got %h want %h", k, i, ctl, ec[i]); end
                step();
            end
            exp_ret = exp_ret + 4'd1;
            n_cmp++; if (retired !== exp_ret) begin n_fail++; $display("FAIL addi%0d_retired: got %0d want %0d", k, retired, exp_ret); end
        end
    endtask

    task automatic test_rst_mid();
        instr = 32'h8C080004; mem_ready = 1'b1;
        step(); step(); step();
        n_cmp++; if (state !== S_MEMRD) begin n_fail++; $display("FAIL rstmid_pre_state: got %0d want %0d", state, S_MEMRD); end
        rst = 1'b1;
        #1;
        n_cmp++; if (ctl !== 16'h0) begin n_fail++; $display("FAIL rstmid_ctl: got %h want %h", ctl, 16'h0); end
        step();
        rst = 1'b0;
        exp_ret = 4'd0;
        #1;
        n_cmp++; if (state !== S_FETCH) begin n_fail++; $display("FAIL rstmid_state: got %0d want %0d", state, S_FETCH); end
        n_cmp++; if (retired !== exp_ret) begin n_fail++; $display("FAIL rstmid_retired: got %0d want %0d", retired, exp_ret); end
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (state !== S_FETCH) begin n_fail++; $display("FAIL to_state[%0d]: got %0d want %0d", i, state, S_FETCH); end
            n_cmp++; if (ctl !== 16'h8040) begin n_fail++; $display("FAIL to_ctl[%0d]: got %h want %h", i, ctl, 16'h8040); end
            step();
        end
        n_cmp++; if (state !== S_FAULT) begin n_fail++; $display("FAIL to_fault_state: got %0d want %0d", state, S_FAULT); end
        n_cmp++; if (fault !== 1'b1) begin n_fail++; $display("FAIL to_fault: got %b want 1", fault); end
        n_cmp++; if (fault_code !== 2'b10) begin n_fail++; $display("FAIL to_code: got %b want 10", fault_code); end
        n_cmp++; if (ctl !== 16'h0) begin n_fail++; $display("FAIL to_ctl_fault: got %h want %h", ctl, 16'h0); end
        n_cmp++; if (retired !== exp_ret) begin n_fail++; $display("FAIL to_retired: got %0d want %0d", retired, exp_ret); end
        mem_ready = 1'b1;
        step(); step();
        n_cmp++; if (state !== S_FAULT) begin n_fail++; $display("FAIL to_held_state: got %0d want %0d", state, S_FAULT); end
        apply_reset();
        n_cmp++; if (state !== S_FETCH) begin n_fail++; $display("FAIL to_rst_state: got %0d want %0d", state, S_FETCH); end
        n_cmp++; if (fault !== 1'b0) begin n_fail++; $display("FAIL to_rst_fault: got %b want 0", fault); end
        n_cmp++; if (fault_code !== 2'b00) begin n_fail++; $display("FAIL to_rst_code: got %b want 00", fault_code); end
    endtask

    task automatic test_illegal();
        logic [31:0] ins[$];
        ins = '{32'hFC000000, 32'h00000001, 32'h14000000};
        for (int k = 0; k < ins.size(); k++) begin
            apply_reset();
            mem_ready = 1'b1; zero = 1'b0; instr = ins[k];
            step();
            n_cmp++; if (state !== S_DECODE) begin n_fail++; $display("FAIL ill%0d_decode: got %0d want %0d", k, state, S_DECODE); end
            step();
`ifdef BNE_EN
            if (k == 2) begin
                n_cmp++; if (state !== S_BRANCH) begin n_fail++; $display("FAIL bne_state: got %0d want %0d", state, S_BRANCH); end
                n_cmp++; if (ctl !== 16'h0B18) begin n_fail++; $display("FAIL bne_ctl: got %h want %h", ctl, 16'h0B18); end
                step();
                n_cmp++; if (retired !== 4'd1) begin n_fail++; $display("FAIL bne_retired: got %0d want 1", retired); end
                continue;
            end
`endif
            n_cmp++; if (state !== S_FAULT) begin n_fail++; $display("FAIL ill%0d_state: got %0d want %0d", k, state, S_FAULT); end
            n_cmp++; if (fault !== 1'b1) begin n_fail++; $display("FAIL ill%0d_fault: got %b want 1", k, fault); end
            n_cmp++; if (fault_code !== 2'b01) begin n_fail++; $display("FAIL ill%0d_code: got %b want 01", k, fault_code); end
            n_cmp++; if (ctl !== 16'h0) begin n_fail++; $display("FAIL ill%0d_ctl: got %h want %h", k, ctl, 16'h0); end
            step(); step();
            n_cmp++; if (state !== S_FAULT) begin n_fail++; $display("FAIL ill%0d_held: got %0d want %0d", k, state, S_FAULT); end
            n_cmp++; if (ctl !== 16'h0) begin n_fail++; $display("FAIL ill%0d_held_ctl: got %h want %h", k, ctl, 16'h0); end
            n_cmp++; if (retired !== 4'd0) begin n_fail++; $display("FAIL ill%0d_retired: got %0d want 0", k, retired); end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_mem_wait();
        test_rtype();
        test_branch();
        test_jump();
        test_wrap();
        test_rst_mid();
        test_timeout();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multi-cycle successor to the single-cycle main decoder. It sequences each MIPS instruction over several clock cycles and shares one memory port for instruction fetch and data access. Sits between the instruction register/datapath and the unified memory, and drives the PC, IR, register-file, ALU-mux and memory enables. Adds a memory ready handshake with timeout, an illegal-instruction fault and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, cycles a memory request may wait for mem_ready before fault; 0 disables timeout
RET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
instr  in  32  IR contents; opcode [31:26], funct [5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory access request
memwrite  out  1  write request (qualifies mem_req)
iord  out  1  0 = PC address, 1 = ALU-out address
irwrite  out  1  load IR
pcen  out  1  PC write enable
pcsrc  out  2  00 ALU result, 01 ALU-out (branch target), 10 jump target
alusrca  out  1  0 = PC, 1 = rs
alusrcb  out  2  00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
op  out  3  ALU op: 000 add, 100 and, 010 or, 011 sub, 111 slt
regwrite  out  1  register-file write
regdst  out  1  1 = rd, 0 = rt
mem2reg  out  1  1 = memory data, 0 = ALU-out
fault  out  1  sticky fault flag
fault_code  out  2  00 none, 01 illegal instr, 10 mem timeout
retired  out  RET_W  retired-instruction count, wraps modulo 2^RET_W
state  out  4  current state encoding (debug)

Behaviour:
- Reset: while rst=1, all control outputs are forced 0. On the next edge: state<=FETCH, retired<=0, fault<=0, fault_code<=00, wait counter<=0. The first post-reset cycle is FETCH.
- Outputs are Moore from state. Exceptions: pcen/irwrite in FETCH are gated by mem_ready, and pcen in BRANCH equals zero. Unlisted outputs are 0.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, op=000, pcsrc=00. If mem_ready: irwrite=1, pcen=1, go to DECODE. Otherwise stay.
- DECODE: alusrca=0, alusrcb=11, op=000 (precomputes branch target). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 with funct in {100000,100100,100101,100010,101010} -> EXEC_R
  - 001000 -> EXEC_I
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - anything else -> FAULT with code 01
- MEMADR: alusrca=1, alusrcb=10, op=000. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. On mem_ready go to MEMWB.
- MEMWB: regwrite=1, regdst=0, mem2reg=1. Go to FETCH; retire.
- MEMWR: mem_req=1, memwrite=1, iord=1. On mem_ready go to FETCH; retire.
- EXEC_R: alusrca=1, alusrcb=00, op from funct (add 000, and 100, or 010, sub 011, slt 111). Go to RWB.
- RWB: regwrite=1, regdst=1, mem2reg=0. Go to FETCH; retire.
- EXEC_I: alusrca=1, alusrcb=10, op=000. Go to IWB.
- IWB: regwrite=1, regdst=0, mem2reg=0. Go to FETCH; retire.
- BRANCH: alusrca=1, alusrcb=00, op=011, pcsrc=01, pcen=zero. Go to FETCH; retire.
- JUMP: pcsrc=10, pcen=1. Go to FETCH; retire.
- FAULT: all controls 0, fault=1, fault_code held. Stays in FAULT until rst.
- Retire: retired increments by 1 on the edge leaving a final state. All-ones wraps to 0.
- Latency: lw 5 states, sw 4, R-type and addi 4, beq and j 3, plus one cycle per memory wait cycle.
- Wait counter:
  - Counts consecutive cycles in a mem_req state with mem_ready=0, and clears on state change.
  - When MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT, go to FAULT with code 10.
  - mem_ready=1 in the same cycle the counter reaches the limit is treated as success.
- instr is sampled only in DECODE, MEMADR, EXEC_R and later states. Changes in FETCH are ignored.
- rst mid-instruction: abandons the instruction with no retire, and drops any pending request.

Optional Feature:
BNE_EN: when defined, opcode 000101 (bne) goes from DECODE to BRANCH with the same controls, except pcen=~zero. When undefined, 000101 is illegal: FAULT, code 01.

Test Plan:
- Reset then instr=0x8C080004 (lw), mem_ready always 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; in MEMWB regwrite=1, mem2reg=1, regdst=0; retired=1.
- instr=0x01095020 (add) then 0x0109502A (slt) -> EXEC_R op=000 then op=111; RWB regwrite=1, regdst=1; retired=2 after both.
- beq 0x11090003 with zero=1, then repeated with zero=0 -> BRANCH pcen=1, pcsrc=01 first; pcen=0 second; both retire.
- FETCH with mem_ready held low, MEM_TIMEOUT=4 -> FAULT after 4 wait cycles, fault_code=10, no retire; rst pulse -> FETCH, fault=0.
- instr opcode 111111, and R-type funct 000001 -> FAULT with code 01, controls all 0 while held. Opcode 000101 -> FAULT without BNE_EN; with BNE_EN, branch taken when zero=0.
- RET_W=4: retire 16 addi (0x21080001) -> retired wraps 15 -> 0; rst asserted during MEMRD -> no increment, FETCH next.
